spi_mem_responder: RTL and testbench

Synthesizable SPI serial-memory responder: the memory-side end of the SPI bus the RV32E MCU uses as initiator for instruction fetch and data access. It decodes the 23LC-style READ/WRITE command set on mode-0 SPI and serves a byte-addressed on-chip array. It sits in the test harness or a companion FPGA image, directly opposite the MCU's SPI pins. All SPI inputs are oversampled on the system clock.

---
 rtl/spi_mem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// Mode-0 SPI serial-memory responder (23LC-style READ 0x03 / WRITE 0x02) backed by a byte array.
// Optional FAST READ (0x0B, 8 dummy clocks) is enabled by defining SPI_MEM_FAST_READ_EN.
module spi_mem_responder #(
   parameter int ADDR_W = 24,
   parameter int DEPTH  = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic spi_sclk,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic spi_miso_oe,
   output logic busy
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(ADDR_W + 1);
   localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef SPI_MEM_FAST_READ_EN
   localparam logic [7:0] OP_FAST  = 8'h0B;
`endif

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
`ifdef SPI_MEM_FAST_READ_EN
   localparam logic [2:0] ST_DUMMY  = 3'd3;
`endif
   localparam logic [2:0] ST_RDATA  = 3'd4;
   localparam logic [2:0] ST_WDATA  = 3'd5;
   localparam logic [2:0] ST_IGNORE = 3'd6;

   logic              sclk_s1_q, sclk_s2_q, sclk_p_q;
   logic              cs_s1_q, cs_s2_q, cs_p_q;
   logic              mosi_s1_q, mosi_s2_q;
   logic [1:0]        sync_ok_q;
   logic              armed_q, armed_d;
   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        op_q, op_d;
   logic [6:0]        sh_q, sh_d;
   logic [6:0]        tx_q, tx_d;
   logic              miso_q, miso_d;
   logic              oe_q, oe_d;
   logic              wr_en;
   logic [7:0]        mem_q [DEPTH];

   logic       sclk_rise, sclk_fall, cs_fall;
   logic [7:0] shift_in, rd_byte;

   function automatic logic opcode_known(input logic [7:0] op);
`ifdef SPI_MEM_FAST_READ_EN
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_FAST);
`else
      return (op == OP_READ) || (op == OP_WRITE);
`endif
   endfunction

   assign sclk_rise = sclk_s2_q & ~sclk_p_q;
   assign sclk_fall = ~sclk_s2_q & sclk_p_q;
   // A cs_n fall only counts once a genuine idle-high level has been seen since reset.
   assign cs_fall   = armed_q & cs_p_q & ~cs_s2_q;
   assign armed_d   = armed_q | (sync_ok_q[1] & cs_s2_q);
   assign shift_in  = {sh_q, mosi_s2_q};
   assign rd_byte   = mem_q[addr_q[IDX_W-1:0]];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      miso_d  = miso_q;
      oe_d    = oe_q;
      wr_en   = 1'b0;
      if (cs_s2_q) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d = ST_CMD;
                  cnt_d   = '0;
                  if (sclk_rise) begin
                     sh_d  = shift_in[6:0];
                     cnt_d = CNT_W'(1);
                  end
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  sh_d  = shift_in[6:0];
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_BYTE_LAST) begin
                     cnt_d   = '0;
                     op_d    = shift_in;
                     state_d = opcode_known(shift_in) ? ST_ADDR : ST_IGNORE;
                  end
               end
            end
            ST_ADDR: begin
               if (sclk_rise) begin
                  addr_d = {addr_q[ADDR_W-2:0], mosi_s2_q};
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_ADDR_LAST) begin
                     cnt_d = '0;
                     if (op_q == OP_WRITE)
                        state_d = ST_WDATA;
`ifdef SPI_MEM_FAST_READ_EN
                     else if (op_q == OP_FAST)
                        state_d = ST_DUMMY;
`endif
                     else
                        state_d = ST_RDATA;
                  end
               end
            end
`ifdef SPI_MEM_FAST_READ_EN
            ST_DUMMY: begin
               if (sclk_rise) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_BYTE_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_RDATA;
                  end
               end
            end
`endif
            ST_RDATA: begin
               // cnt_q==0 marks a byte boundary: fetch and present its MSB.
               if (sclk_fall) begin
                  oe_d = 1'b1;
                  if (cnt_q == '0) begin
                     tx_d   = rd_byte[6:0];
                     miso_d = rd_byte[7];
                     cnt_d  = CNT_W'(1);
                  end else begin
                     tx_d   = {tx_q[5:0], 1'b0};
                     miso_d = tx_q[6];
                     cnt_d  = cnt_q + CNT_W'(1);
                     if (cnt_q == CNT_BYTE_LAST) begin
                        cnt_d  = '0;
                        addr_d = addr_q + ADDR_W'(1);
                     end
                  end
               end
            end
            ST_WDATA: begin
               if (sclk_rise) begin
                  sh_d  = shift_in[6:0];
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_BYTE_LAST) begin
                     wr_en  = 1'b1;
                     cnt_d  = '0;
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
            ST_IGNORE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_p_q  <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         cs_p_q    <= 1'b1;
         sync_ok_q <= 2'b00;
         armed_q   <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         sclk_s1_q <= spi_sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_p_q  <= sclk_s2_q;
         cs_s1_q   <= spi_cs_n;
         cs_s2_q   <= cs_s1_q;
         cs_p_q    <= cs_s2_q;
         sync_ok_q <= {sync_ok_q[0], 1'b1};
         armed_q   <= armed_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         miso_q    <= miso_d;
         oe_q      <= oe_d;
      end
   end

   always_ff @(posedge clk) begin
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      op_q      <= op_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         mem_q[addr_q[IDX_W-1:0]] <= shift_in;
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign busy        = ~cs_s2_q;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench for spi_mem_responder: a mode-0 initiator drives random frames, a byte-array
// model predicts read data, and a monitor on sclk rises pops and compares each received byte.
module tb_spi_mem_responder;
   localparam int HALF = 4;
`ifdef SPI_MEM_FAST_READ_EN
   localparam bit FAST_EN = 1'b1;
`else
   localparam bit FAST_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, sclk, cs_n, mosi;
   logic miso, oe, busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] ref_mem [256];
   logic [7:0] sb [$];
   logic rd_phase = 1'b0;
   logic oe_seen = 1'b0;
   logic miso_bad = 1'b0;
   logic [7:0] mon_sh = 8'h00;
   int mon_n = 0;

   always #5 clk = ~clk;

   spi_mem_responder #(.ADDR_W(24), .DEPTH(256)) dut (
      .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
      .spi_miso(miso), .spi_miso_oe(oe), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: during a read data phase, collect miso on each sclk rise and compare whole bytes.
   always @(posedge sclk) begin
      if (rd_phase) begin
         check("oe_in_read", {31'd0, oe}, 32'd1);
         mon_sh = {mon_sh[6:0], miso};
         mon_n++;
         if (mon_n == 8) begin
            mon_n = 0;
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("rd_byte", {24'd0, mon_sh}, {24'd0, sb.pop_front()});
         end
      end else begin
         mon_n = 0;
      end
   end

   always @(negedge clk) begin
      if (oe === 1'b1) oe_seen = 1'b1;
      if (oe !== 1'b1 && miso !== 1'b0) miso_bad = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic b);
      mosi = b;
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
   endtask

   task automatic byte_x(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bit_x(b[i]);
   endtask

   task automatic cs_lo();
      oe_seen  = 1'b0;
      miso_bad = 1'b0;
      cs_n = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_hi();
      tick(HALF);
      cs_n = 1'b1;
      tick(6);
      check("miso_zero_when_off", {31'd0, miso_bad}, 32'd0);
      check("busy_after_cs_high", {31'd0, busy}, 32'd0);
   endtask

   task automatic hdr(input logic [7:0] op, input logic [23:0] a);
      byte_x(op);
      byte_x(a[23:16]);
      byte_x(a[15:8]);
      byte_x(a[7:0]);
   endtask

   task automatic do_write(input logic [23:0] a, input logic [7:0] d [$], input int part_bits);
      cs_lo();
      hdr(8'h02, a);
      foreach (d[i]) begin
         byte_x(d[i]);
         ref_mem[(int'(a[7:0]) + i) % 256] = d[i];
      end
      for (int i = 0; i < part_bits; i++) bit_x(1'($urandom_range(0, 1)));
      cs_hi();
      check("oe_during_write", {31'd0, oe_seen}, 32'd0);
   endtask

   task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
      bit expect_data;
      expect_data = (op == 8'h03) || (op == 8'h0B && FAST_EN);
      cs_lo();
      hdr(op, a);
      if (op == 8'h0B) byte_x(8'($urandom));
      if (expect_data) begin
         for (int i = 0; i < n; i++) sb.push_back(ref_mem[(int'(a[7:0]) + i) % 256]);
         rd_phase = 1'b1;
      end
      for (int i = 0; i < n; i++) byte_x(8'($urandom));
      rd_phase = 1'b0;
      cs_hi();
      check("sb_drained", sb.size(), 32'd0);
      sb.delete();
      check("oe_seen_read", {31'd0, oe_seen}, {31'd0, expect_data});
   endtask

   task automatic do_unknown(input logic [7:0] op, input int nbits);
      cs_lo();
      byte_x(op);
      for (int i = 0; i < nbits; i++) bit_x(1'($urandom_range(0, 1)));
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      cs_hi();
      check("oe_unknown_op", {31'd0, oe_seen}, 32'd0);
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] op;
      int k;
      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tick(5);
      rst = 1'b0;
      tick(1);
      check("rst_oe", {31'd0, oe}, 32'd0);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      tick(4);

      // Fill the whole array once so every later read has a known model value.
      q = {};
      for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
      do_write(24'($urandom), q, 0);

      q = {8'hA5, 8'h3C};
      do_write(24'h000010, q, 0);
      do_read(8'h03, 24'h000010, 2);

      q = {8'h11, 8'h22};
      do_write(24'h0000FF, q, 0);
      do_read(8'h03, 24'h000000, 1);
      do_read(8'h03, 24'h0000FF, 1);

      do_unknown(8'h9F, 32);
      do_read(8'h03, 24'h000010, 2);

      q = {};
      do_write(24'h000020, q, 5);
      do_read(8'h03, 24'h000020, 1);

      do_read(8'h0B, 24'h000010, 1);

      // Reset in the middle of a read data phase.
      cs_lo();
      hdr(8'h03, 24'h000010);
      bit_x(1'b0); bit_x(1'b0);
      k = 0;
      while (oe !== 1'b1 && k < 20) begin tick(1); k++; end
      check("oe_before_rst", {31'd0, oe}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("oe_after_rst", {31'd0, oe}, 32'd0);
      check("miso_after_rst", {31'd0, miso}, 32'd0);
      oe_seen = 1'b0;
      for (int i = 0; i < 8; i++) bit_x(1'b0);
      check("ignored_after_rst", {31'd0, oe_seen}, 32'd0);
      cs_hi();
      do_read(8'h03, 24'h000010, 2);

      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               q = {};
               for (int i = 0; i < int'($urandom_range(1, 4)); i++) q.push_back(8'($urandom));
               do_write(24'($urandom), q, 0);
            end
            1: do_read(8'h03, 24'($urandom), int'($urandom_range(1, 4)));
            2: begin
               q = {};
               for (int i = 0; i < int'($urandom_range(0, 2)); i++) q.push_back(8'($urandom));
               do_write(24'($urandom), q, int'($urandom_range(1, 7)));
            end
            3: begin
               op = 8'($urandom);
               if (op == 8'h02 || op == 8'h03 || op == 8'h0B) op = 8'h9F;
               do_unknown(op, int'($urandom_range(8, 40)));
            end
            default: do_read(8'h0B, 24'($urandom), int'($urandom_range(1, 3)));
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
